// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// bubble instruction and alignment mask.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: issues the current PC on the instruction bus,
// holds the returned word in a one-entry IF/ID buffer and gates PC advance.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_REQ  | requesting pc_i on the bus (or trapping a misaligned pc_i)
// S_WAIT | request accepted, waiting for read data
// S_DROP | flushed while waiting; swallow the stale response
// S_FULL | buffer holds an instruction (or fetch error) for decode
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             flush_i,
  input  logic             id_stall_i,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             pc_en_o,
  output logic             if_valid_o,
  output logic [WIDTH-1:0] if_pc_o,
  output logic [WIDTH-1:0] if_inst_o,
  output logic             if_adel_o
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [WIDTH-1:0] buf_inst_q, buf_inst_d;
  logic             buf_adel_q, buf_adel_d;
  logic             pc_misaligned;

  assign pc_misaligned = (pc_i[1:0] & ALIGN_MASK) != 2'b00;

  assign inst_addr  = pc_i;
  assign inst_req   = (state_q == S_REQ) & ~flush_i & ~rst & ~pc_misaligned;
  assign pc_en_o    = (state_q == S_FULL) & ~id_stall_i & ~flush_i & ~rst;
  assign if_valid_o = (state_q == S_FULL);
  assign if_pc_o    = buf_pc_q;
  assign if_inst_o  = buf_inst_q;
  assign if_adel_o  = buf_adel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      req_pc_q   <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      buf_adel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_adel_q <= buf_adel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    buf_adel_d = buf_adel_q;

    unique case (state_q)
      S_REQ: begin
        // A misaligned PC never reaches the bus; it becomes an error entry.
        if (!flush_i) begin
          if (pc_misaligned) begin
            buf_pc_d   = pc_i;
            buf_inst_d = WIDTH'(NOP_INST);
            buf_adel_d = 1'b1;
            state_d    = S_FULL;
          end else if (inst_req && inst_addr_ok) begin
            req_pc_d = pc_i;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (flush_i) begin
            state_d = S_REQ;
          end else begin
            buf_pc_d   = req_pc_q;
            buf_inst_d = inst_rdata;
            buf_adel_d = 1'b0;
            state_d    = S_FULL;
          end
        end else if (flush_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (inst_data_ok) state_d = S_REQ;
      end
      S_FULL: begin
        if (flush_i || !id_stall_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: zero-wait fetch, back-pressure, delayed
// accept, flush while waiting, misaligned PC and reset while full.
module tb_inst_fetch_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc_i;
  logic             flush_i;
  logic             id_stall_i;
  logic             inst_req;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_addr_ok;
  logic             inst_data_ok;
  logic [WIDTH-1:0] inst_rdata;
  logic             pc_en_o;
  logic             if_valid_o;
  logic [WIDTH-1:0] if_pc_o;
  logic [WIDTH-1:0] if_inst_o;
  logic             if_adel_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_hs;

  inst_fetch_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pc_en_o      (pc_en_o),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_adel_o    (if_adel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge and
  // outputs are sampled 1ns later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; flush_i = 1'b0; id_stall_i = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    tick(); tick();

    // reset state
    pc_i = 32'hBFC0_0000;
    settle();
    chk("rst_req",   {31'd0, inst_req},   32'd0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_pc",    if_pc_o,             32'd0);
    chk("rst_inst",  if_inst_o,           32'd0);
    chk("rst_adel",  {31'd0, if_adel_o},  32'd0);

    // zero-wait fetch
    rst = 1'b0; settle();
    chk("zw_req",  {31'd0, inst_req}, 32'd1);
    chk("zw_addr", inst_addr,         32'hBFC0_0000);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
    settle();
    chk("zw_wait_req", {31'd0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'hFFFF_FFFF;
    settle();
    chk("zw_valid", {31'd0, if_valid_o}, 32'd1);
    chk("zw_pc",    if_pc_o,             32'hBFC0_0000);
    chk("zw_inst",  if_inst_o,           32'h2408_0001);
    chk("zw_adel",  {31'd0, if_adel_o},  32'd0);
    chk("zw_pcen",  {31'd0, pc_en_o},    32'd1);
    tick();
    pc_i = 32'hBFC0_0004; settle();
    chk("zw_next_valid", {31'd0, if_valid_o}, 32'd0);
    chk("zw_next_req",   {31'd0, inst_req},   32'd1);

    // back-pressure
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C09_0010;
    tick();
    inst_data_ok = 1'b0; id_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_valid", {31'd0, if_valid_o}, 32'd1);
      chk("bp_inst",  if_inst_o,           32'h8C09_0010);
      chk("bp_pc",    if_pc_o,             32'hBFC0_0004);
      chk("bp_pcen",  {31'd0, pc_en_o},    32'd0);
      tick();
    end
    id_stall_i = 1'b0; settle();
    chk("bp_release_pcen", {31'd0, pc_en_o}, 32'd1);
    tick();
    settle();
    chk("bp_after_valid", {31'd0, if_valid_o}, 32'd0);

    // delayed addr_ok
    pc_i = 32'hBFC0_0008; n_hs = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("dly_req",  {31'd0, inst_req}, 32'd1);
      chk("dly_addr", inst_addr,         32'hBFC0_0008);
      if (inst_req && inst_addr_ok) n_hs++;
      tick();
    end
    inst_addr_ok = 1'b1; settle();
    if (inst_req && inst_addr_ok) n_hs++;
    tick();
    settle();
    if (inst_req && inst_addr_ok) n_hs++;
    chk("dly_handshakes", n_hs, 32'd1);
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_1234;
    tick();
    inst_data_ok = 1'b0; settle();
    chk("dly_pc",   if_pc_o,   32'hBFC0_0008);
    chk("dly_inst", if_inst_o, 32'h0000_1234);
    tick();

    // flush while waiting; stale data must be swallowed
    pc_i = 32'hBFC0_000C; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; flush_i = 1'b1; pc_i = 32'hBFC0_0380;
    settle();
    chk("fl_req", {31'd0, inst_req}, 32'd0);
    tick();
    flush_i = 1'b0; settle();
    chk("fl_drop_req",   {31'd0, inst_req},   32'd0);
    chk("fl_drop_valid", {31'd0, if_valid_o}, 32'd0);
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; settle();
    chk("fl_data_req", {31'd0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b0; settle();
    chk("fl_after_valid", {31'd0, if_valid_o}, 32'd0);
    chk("fl_after_req",   {31'd0, inst_req},   32'd1);
    chk("fl_after_addr",  inst_addr,           32'hBFC0_0380);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_2222;
    tick();
    inst_data_ok = 1'b0; settle();
    chk("fl_new_pc",   if_pc_o,   32'hBFC0_0380);
    chk("fl_new_inst", if_inst_o, 32'h1111_2222);

    // flush in FULL: entry dropped without advancing the PC
    flush_i = 1'b1; settle();
    chk("flf_pcen", {31'd0, pc_en_o}, 32'd0);
    tick();
    flush_i = 1'b0; settle();
    chk("flf_valid", {31'd0, if_valid_o}, 32'd0);

    // misaligned PC; stray data_ok in REQ must be ignored
    pc_i = 32'hBFC0_0002; inst_data_ok = 1'b1; settle();
    chk("mis_req", {31'd0, inst_req}, 32'd0);
    tick();
    inst_data_ok = 1'b0; id_stall_i = 1'b1; settle();
    chk("mis_valid", {31'd0, if_valid_o}, 32'd1);
    chk("mis_adel",  {31'd0, if_adel_o},  32'd1);
    chk("mis_inst",  if_inst_o,           32'd0);
    chk("mis_pc",    if_pc_o,             32'hBFC0_0002);

    // reset while FULL
    rst = 1'b1; id_stall_i = 1'b0; pc_i = 32'hBFC0_0000; settle();
    chk("rf_req",  {31'd0, inst_req}, 32'd0);
    chk("rf_pcen", {31'd0, pc_en_o},  32'd0);
    tick();
    rst = 1'b0; settle();
    chk("rf_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rf_adel",  {31'd0, if_adel_o},  32'd0);
    chk("rf_pc",    if_pc_o,             32'd0);
    chk("rf_req_after", {31'd0, inst_req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
